// File: rtl/mdu_scheduler_if.sv
// Bundle of the alpha/beta MDU request handshakes, the HI/LO read hints,
// the shared multiply/divide engine link and the scheduler status outputs.
// The pipeline/engine side uses the master modport; the scheduler uses slave.
interface mdu_scheduler_if #(
    parameter int DATA_W = 32
);
    logic                  flush_i;

    logic                  a_valid;
    logic [2:0]            a_op;
    logic [DATA_W-1:0]     a_src_a;
    logic [DATA_W-1:0]     a_src_b;
    logic                  a_ready;

    logic                  b_valid;
    logic [2:0]            b_op;
    logic [DATA_W-1:0]     b_src_a;
    logic [DATA_W-1:0]     b_src_b;
    logic                  b_ready;

    logic                  a_hilo_rd;
    logic                  b_hilo_rd;

    logic                  eng_start;
    logic [1:0]            eng_op;
    logic [DATA_W-1:0]     eng_a;
    logic [DATA_W-1:0]     eng_b;
    logic                  eng_done;
    logic [2*DATA_W-1:0]   eng_result;

    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  busy_o;
    logic                  stall_o;

    modport master (
        output flush_i,
        output a_valid, a_op, a_src_a, a_src_b,
        input  a_ready,
        output b_valid, b_op, b_src_a, b_src_b,
        input  b_ready,
        output a_hilo_rd, b_hilo_rd,
        input  eng_start, eng_op, eng_a, eng_b,
        output eng_done, eng_result,
        input  hi_o, lo_o, busy_o, stall_o
    );

    modport slave (
        input  flush_i,
        input  a_valid, a_op, a_src_a, a_src_b,
        output a_ready,
        input  b_valid, b_op, b_src_a, b_src_b,
        output b_ready,
        input  a_hilo_rd, b_hilo_rd,
        output eng_start, eng_op, eng_a, eng_b,
        input  eng_done, eng_result,
        output hi_o, lo_o, busy_o, stall_o
    );
endinterface

// File: rtl/mdu_scheduler.sv
// Execute-stage scheduler that shares one iterative multiply/divide engine
// and the architectural HI/LO pair between the alpha and beta pipelines.
// Only one MDU operation is ever in flight, so HI/LO writes (engine commits
// and MTHI/MTLO) land in the same order the instructions were accepted.
module mdu_scheduler #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mdu_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_t              state_q;
    state_t              state_d;

    logic                grant_a;
    logic                grant_b;
    logic                accept;
    logic [2:0]          sel_op;
    logic [DATA_W-1:0]   sel_src_a;
    logic [DATA_W-1:0]   sel_src_b;
    logic                acc_mdu;
    logic                acc_mthi;
    logic                acc_mtlo;
    logic                commit;

    logic [1:0]          eng_op_q;
    logic [DATA_W-1:0]   eng_a_q;
    logic [DATA_W-1:0]   eng_b_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    // Fixed-priority grant (alpha is older) and selection of the winning request
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        sel_op    = bus.b_op;
        sel_src_a = bus.b_src_a;
        sel_src_b = bus.b_src_b;
        if (state_q == IDLE && !bus.flush_i) begin
            grant_a = bus.a_valid;
            grant_b = bus.b_valid & ~bus.a_valid;
        end
        if (grant_a) begin
            sel_op    = bus.a_op;
            sel_src_a = bus.a_src_a;
            sel_src_b = bus.a_src_b;
        end
        accept   = grant_a | grant_b;
        acc_mdu  = accept & ~sel_op[2];
        acc_mthi = accept & (sel_op == OP_MTHI);
        acc_mtlo = accept & (sel_op == OP_MTLO);
        commit   = (state_q == WAIT) & bus.eng_done;
    end

    // State register; reset abandons any operation still in the engine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing and handshake/status outputs
    always_comb begin
        state_d       = state_q;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        bus.eng_start = 1'b0;
        bus.busy_o    = (state_q != IDLE);
        bus.stall_o   = 1'b0;

        case (state_q)
            IDLE: begin
                bus.a_ready = rst & grant_a;
                bus.b_ready = rst & grant_b;
                if (acc_mdu) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.eng_start = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // There is no forwarding path, so a HI/LO reader waits out any pending result
        bus.stall_o = rst & ~bus.flush_i & (bus.a_hilo_rd | bus.b_hilo_rd)
                      & ((state_q != IDLE) | accept);
    end

    // Latch op and operands for the engine when a multiply/divide is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_op_q <= 2'd0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
        end else if (acc_mdu) begin
            eng_op_q <= sel_op[1:0];
            eng_a_q  <= sel_src_a;
            eng_b_q  <= sel_src_b;
        end
    end

    // HI/LO update: engine commit in WAIT, or MTHI/MTLO directly from IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= bus.eng_result[2*DATA_W-1:DATA_W];
            lo_q <= bus.eng_result[DATA_W-1:0];
        end else begin
            if (acc_mthi) begin
                hi_q <= sel_src_a;
            end
            if (acc_mtlo) begin
                lo_q <= sel_src_a;
            end
        end
    end

    assign bus.eng_op = eng_op_q;
    assign bus.eng_a  = eng_a_q;
    assign bus.eng_b  = eng_b_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

    // Only the low operand is used by MTHI/MTLO; src_b matters for engine ops only
    logic unused_ok;
    assign unused_ok = ^{sel_src_b[0]};

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Shares one iterative multiply/divide engine and the architectural HI/LO register pair between the alpha and beta issue pipelines.
- Accepts MDU requests from either pipeline and sequences the engine through start, wait and commit.
- Applies MTHI/MTLO writes to HI/LO.
- Stalls both pipelines while any instruction needs HI/LO and a result is still outstanding.
- Sits in the execute stage between the two ALUs and the shared engine.

Parameters:
DATA_W, 32, operand width; HI/LO are each DATA_W bits, engine result is 2*DATA_W bits.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
flush_i  in  1  pipeline flush; blocks new grants
a_valid  in  1  alpha pipeline presents an MDU request
a_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
a_src_a  in  DATA_W  rs operand
a_src_b  in  DATA_W  rt operand
a_ready  out  1  alpha request accepted this cycle
b_valid, b_op, b_src_a, b_src_b, b_ready  same as alpha, for the beta pipeline
a_hilo_rd  in  1  alpha instruction reads HI/LO (MFHI/MFLO)
b_hilo_rd  in  1  beta instruction reads HI/LO
eng_start  out  1  one-cycle start pulse to the engine
eng_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
eng_a  out  DATA_W  latched operand A
eng_b  out  DATA_W  latched operand B
eng_done  in  1  one-cycle pulse, result valid
eng_result  in  2*DATA_W  {hi, lo}
hi_o  out  DATA_W  current HI
lo_o  out  DATA_W  current LO
busy_o  out  1  state != IDLE
stall_o  out  1  hold both pipelines

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state IDLE
  - hi_o = lo_o = 0
  - eng_start = 0
  - eng_op, eng_a, eng_b = 0
  - busy_o = 0
- Ready/stall outputs are combinational and evaluate to 0 while rst=0.
- A late eng_done arriving after reset is ignored.
- States are IDLE, ISSUE and WAIT.
- IDLE, grant:
  - Only when flush_i=0.
  - Fixed priority alpha over beta, because alpha is older in program order.
  - a_ready = a_valid & !flush_i.
  - b_ready = b_valid & !a_valid & !flush_i.
  - A beta request in the same cycle as an alpha request waits.
  - Accept is valid & ready.
- IDLE, accepted op:
  - op 0-3: latch operands and op into eng_a/eng_b/eng_op; next state ISSUE.
  - op 4 (MTHI): HI <= src_a at the same edge; stay IDLE.
  - op 5 (MTLO): LO <= src_a at the same edge; stay IDLE.
  - op 6-7: accepted and ignored; no state change.
- ISSUE:
  - eng_start = 1 for exactly this cycle.
  - Next state WAIT.
- WAIT:
  - Remain until eng_done=1.
  - At that edge {HI, LO} <= eng_result and next state is IDLE.
  - eng_done outside WAIT is ignored.
- ISSUE and WAIT:
  - a_ready = b_ready = 0.
  - A second MDU request blocks until IDLE, including MTHI/MTLO, so write order to HI/LO is preserved.
- flush_i=1 during ISSUE or WAIT does not cancel: an accepted operation has passed the exception point and always commits.
- stall_o = !flush_i & (a_hilo_rd | b_hilo_rd) & (busy_o | accept_this_cycle).
  - Same-bundle pairs such as MULT in alpha with MFLO in beta stall one or more cycles.
  - There is no forwarding.
- The first cycle a reader is unstalled is the cycle after the commit edge; hi_o/lo_o already hold the new value.
- Division by zero: no special handling; whatever the engine returns is committed.
- Signed/unsigned semantics are owned by the engine; this block only maps a_op/b_op[1:0] straight onto eng_op.
- Latency, accept to commit: 2 cycles + engine latency (IDLE→ISSUE→WAIT→done edge).

Test Plan:
- Alpha MULT, src_a=0xFFFFFFFD, src_b=5; engine returns 0xFFFFFFFF_FFFFFFF1 four cycles after start -> eng_start is a single pulse one cycle after accept; hi_o=0xFFFFFFFF and lo_o=0xFFFFFFF1 the cycle after eng_done; busy_o drops at the same time.
- a_valid and b_valid together (alpha DIVU 7/2, beta MTHI 0x1234) -> a_ready=1, b_ready=0 until return to IDLE; final hi_o=0x1234, lo_o=3, confirming the MTHI after DIVU ordering.
- MULT accepted in alpha with b_hilo_rd=1 in the same cycle -> stall_o=1 from the accept cycle through the eng_done cycle; 0 on the next cycle, with the new LO visible.
- flush_i=1 in IDLE with a_valid=1 -> a_ready=0, no eng_start, no state change; flush_i=1 during WAIT -> result still committed.
- rst asserted mid-WAIT, then eng_done pulsed after release -> hi_o=lo_o=0, state IDLE, and the late eng_done is ignored.
- MTLO 0xDEADBEEF, then MFLO next cycle with no busy -> lo_o=0xDEADBEEF and stall_o=0 on the reading cycle.
